// File: rtl/x_300_mod_241_serial.sv
// Serial residue unit: R = X mod 241 for a 300-bit operand, folding LANES
// 24-bit chunks per cycle into a canonical 8-bit accumulator (2^24 == 1 mod 241).
module x_300_mod_241_serial #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [300:1] X,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [8:1]   R,
  output logic         busy
);
  localparam int NSTEP = (13 + LANES - 1) / LANES;
  localparam int SHIFT = 24 * LANES;

  // Handshake: an operand moves on a rising edge with in_valid & in_ready, a
  // result moves on a rising edge with out_valid & out_ready; neither ready
  // nor valid ever depends combinationally on the other side.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t       r_state;
  logic [311:0] r_sh;
  logic [7:0]   r_acc;
  logic [3:0]   r_cnt;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;
  logic [7:0]   r_res;

  logic [19:0]  w_sum;
  logic [15:0]  w_f1;
  logic [11:0]  w_f2;
  logic [8:0]   w_f3;
  logic [7:0]   w_red;

  // Worst case LANES=13: 13*61455 + 240 < 2^20, so 20 bits hold the sum exactly.
  always_comb begin
    w_sum = {12'd0, r_acc};
    for (int l = 0; l < LANES; l++) begin
      w_sum = w_sum
            + 20'(r_sh[24*l +: 8])
            + 20'(r_sh[24*l+8 +: 8]) * 20'd15
            + 20'(r_sh[24*l+16 +: 8]) * 20'd225;
    end
  end

  // Three folds by 2^8 == 15 bring any 20-bit value below 482; one subtract finishes.
  always_comb begin
    w_f1  = 16'(w_sum[7:0]) + 16'(w_sum[19:8]) * 16'd15;
    w_f2  = 12'(w_f1[7:0]) + 12'(w_f1[15:8]) * 12'd15;
    w_f3  = 9'(w_f2[7:0]) + 9'(w_f2[11:8]) * 9'd15;
    w_red = (w_f3 >= 9'd241) ? 8'(w_f3 - 9'd241) : w_f3[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sh        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_res       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sh       <= {12'd0, X};
            r_acc      <= '0;
            r_cnt      <= 4'(NSTEP);
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_red;
          r_sh  <= r_sh >> SHIFT;
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_res       <= w_red;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign R         = r_res;
endmodule

// File: tb/tb_x_300_mod_241_serial.sv
// Bench for x_300_mod_241_serial: four instances (LANES 1,2,4,13) driven with
// directed vectors, backpressure, mid-RUN reset and random operands.
module tb_x_300_mod_241_serial;
  localparam int ND = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [ND];
  logic         in_ready  [ND];
  logic [299:0] x_in      [ND];
  logic         out_valid [ND];
  logic         out_ready [ND];
  logic [7:0]   r_out     [ND];
  logic         busy      [ND];

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [299:0] x;
    logic [7:0]   r;
  } vec_t;
  vec_t vecs[12];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 13;
    x_300_mod_241_serial #(.LANES(L)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .X         (x_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .R         (r_out[g]),
      .busy      (busy[g])
    );
  end

  function automatic int lanes_of(input int sel);
    case (sel)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 13;
    endcase
  endfunction

  function automatic int nstep_of(input int sel);
    return (13 + lanes_of(sel) - 1) / lanes_of(sel);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic rand_x(output logic [299:0] x);
    x = '0;
    for (int i = 0; i < 10; i++) x = {x[267:0], 32'($urandom)};
  endtask

  // One complete transaction: accept, latency, result, optional stall, transfer.
  task automatic run_op(input int sel, input logic [299:0] x, input logic [7:0] exp,
                        input int pre_idle, input int stall, input bit noisy, input string name);
    int cyc;
    logic [7:0] e;
    logic [299:0] junk;
    bit stall_ok;
    repeat (pre_idle) tick();
    x_in[sel] = x;
    in_valid[sel] = 1'b1;
    cyc = 0;
    while (in_ready[sel] !== 1'b1 && cyc < 50) begin tick(); cyc++; end
    check({name, " in_ready_wait"}, 32'(cyc), 32'd0);
    tick();
    exp_q.push_back(exp);
    in_valid[sel] = 1'b0;
    rand_x(junk);
    x_in[sel] = junk;
    check({name, " busy_after_accept"}, 32'(busy[sel]), 32'd1);
    cyc = 0;
    while (out_valid[sel] !== 1'b1 && cyc < 50) begin
      out_ready[sel] = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      cyc++;
    end
    out_ready[sel] = 1'b0;
    check({name, " latency"}, 32'(cyc), 32'(nstep_of(sel)));
    e = exp_q.pop_front();
    check({name, " R"}, 32'(r_out[sel]), 32'(e));
    check({name, " R_range"}, 32'(r_out[sel] <= 8'd240), 32'd1);
    stall_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      in_valid[sel] = 1'b1;
      rand_x(junk);
      x_in[sel] = junk;
      tick();
      if (out_valid[sel] !== 1'b1 || r_out[sel] !== e || in_ready[sel] !== 1'b0)
        stall_ok = 1'b0;
    end
    if (stall > 0) check({name, " stall_stable"}, 32'(stall_ok), 32'd1);
    in_valid[sel] = 1'b0;
    out_ready[sel] = 1'b1;
    tick();
    out_ready[sel] = 1'b0;
    check({name, " out_valid_dropped"}, 32'(out_valid[sel]), 32'd0);
    check({name, " in_ready_back"}, 32'(in_ready[sel]), 32'd1);
    check({name, " busy_cleared"}, 32'(busy[sel]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [299:0] xv;
    logic [299:0] m;
    bit quiet;

    // Clock/reset block
    rst = 1'b1;
    for (int s = 0; s < ND; s++) begin
      in_valid[s] = 1'b0;
      out_ready[s] = 1'b0;
      x_in[s] = '0;
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    for (int s = 0; s < ND; s++) begin
      check($sformatf("reset d%0d in_ready", s), 32'(in_ready[s]), 32'd1);
      check($sformatf("reset d%0d out_valid", s), 32'(out_valid[s]), 32'd0);
      check($sformatf("reset d%0d busy", s), 32'(busy[s]), 32'd0);
      check($sformatf("reset d%0d R", s), 32'(r_out[s]), 32'd0);
    end

    // Directed vectors with hand-computed residues
    vecs[0].x  = '0;                 vecs[0].r  = 8'd0;
    vecs[1].x  = 300'd240;           vecs[1].r  = 8'd240;
    vecs[2].x  = 300'd241;           vecs[2].r  = 8'd0;
    vecs[3].x  = 300'd1 << 24;       vecs[3].r  = 8'd1;
    vecs[4].x  = 300'd1 << 8;        vecs[4].r  = 8'd15;
    vecs[5].x  = 300'd1 << 16;       vecs[5].r  = 8'd225;
    vecs[6].x  = '1;                 vecs[6].r  = 8'd239;
    vecs[7].x  = 300'd1 << 299;      vecs[7].r  = 8'd120;
    vecs[8].x  = 300'd1000;          vecs[8].r  = 8'd36;
    vecs[9].x  = 300'd12345;         vecs[9].r  = 8'd54;
    vecs[10].x = 300'd1 << 289;      vecs[10].r = 8'd2;
    vecs[11].x = 300'd482;           vecs[11].r = 8'd0;
    for (int s = 0; s < ND; s += 3) begin
      for (int i = 0; i < 12; i++) begin
        run_op(s, vecs[i].x, vecs[i].r, 0, 0, 1'b0, $sformatf("vec%0d d%0d", i, s));
      end
    end

    // Backpressure: 5 stalled cycles in DONE with in_valid held high
    run_op(0, 300'd12345, 8'd54, 1, 5, 1'b0, "backpressure");
    tick();
    check("backpressure no_second_accept", 32'(busy[0]), 32'd0);

    // Reset in the sixth RUN cycle aborts the operand
    x_in[0] = '1;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (5) tick();
    check("abort busy_before_reset", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("abort R_reset", 32'(r_out[0]), 32'd0);
    check("abort out_valid_reset", 32'(out_valid[0]), 32'd0);
    check("abort busy_reset", 32'(busy[0]), 32'd0);
    check("abort in_ready_reset", 32'(in_ready[0]), 32'd1);
    tick();
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) quiet = 1'b0;
    end
    check("abort no_output", 32'(quiet), 32'd1);
    run_op(0, 300'd1000, 8'd36, 0, 0, 1'b0, "after_abort");

    // Random operands against a wide-arithmetic reference
    for (int s = 0; s < ND; s++) begin
      for (int i = 0; i < 100; i++) begin
        rand_x(xv);
        if (i % 10 == 3) xv = xv >> $urandom_range(1, 299);
        m = xv % 300'd241;
        run_op(s, xv, m[7:0], $urandom_range(0, 3), $urandom_range(0, 3), 1'b1,
               $sformatf("rand d%0d #%0d", s, i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
